// File: rtl/hand_source_arbiter.sv
// Left-hand pose source arbiter: picks camera tracker or button-driven pose,
// stages it, and releases it to the renderer only on frame boundaries.
module hand_source_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned CONFIRM_COUNT  = 4
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        cam_valid_in,
  input  logic [11:0] cam_x_bottom_in,
  input  logic [11:0] cam_y_bottom_in,
  input  logic [13:0] cam_z_bottom_in,
  input  logic [11:0] cam_x_top_in,
  input  logic [11:0] cam_y_top_in,
  input  logic [13:0] cam_z_top_in,
  input  logic        man_valid_in,
  input  logic [11:0] man_x_bottom_in,
  input  logic [11:0] man_y_bottom_in,
  input  logic [13:0] man_z_bottom_in,
  input  logic [11:0] man_x_top_in,
  input  logic [11:0] man_y_top_in,
  input  logic [13:0] man_z_top_in,
  input  logic        frame_start_in,
  output logic [11:0] hand_x_left_bottom,
  output logic [11:0] hand_y_left_bottom,
  output logic [13:0] hand_z_left_bottom,
  output logic [11:0] hand_x_left_top,
  output logic [11:0] hand_y_left_top,
  output logic [13:0] hand_z_left_top,
  output logic        pose_valid_out,
  output logic        source_out
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW = $clog2(CONFIRM_COUNT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CONFIRM_LAST = CW'(CONFIRM_COUNT - 1);
  localparam logic DIRECT_HANDOVER = (CONFIRM_COUNT <= 1);

  typedef enum logic [1:0] {MANUAL, ACQUIRE, CAMERA} state_t;

  state_t        state;
  logic [TW-1:0] timeout_cnt;
  logic [CW-1:0] confirm_cnt;
  logic [75:0]   staging;
  logic [75:0]   released;
  logic          pending;

  logic [75:0] cam_pose;
  logic [75:0] man_pose;
  logic        accept;
  logic        timed_out;
  logic        confirm_done;
  logic        cam_wr;
  logic        man_wr;
  logic        to_camera;
  logic        to_manual;
  logic        release_now;

  // Pose packing: {x_bottom, y_bottom, z_bottom, x_top, y_top, z_top}
  assign cam_pose = {cam_x_bottom_in, cam_y_bottom_in, cam_z_bottom_in,
                     cam_x_top_in, cam_y_top_in, cam_z_top_in};
  assign man_pose = {man_x_bottom_in, man_y_bottom_in, man_z_bottom_in,
                     man_x_top_in, man_y_top_in, man_z_top_in};

  assign accept       = cam_valid_in && (cam_z_bottom_in != '0) && (cam_z_top_in != '0);
  assign timed_out    = (timeout_cnt >= TIMEOUT_LAST);
  assign confirm_done = (confirm_cnt >= CONFIRM_LAST);
  assign release_now  = frame_start_in && pending;

  always_comb begin
    cam_wr    = 1'b0;
    man_wr    = 1'b0;
    to_camera = 1'b0;
    to_manual = 1'b0;
    unique case (state)
      MANUAL: begin
        if (accept && DIRECT_HANDOVER) begin
          to_camera = 1'b1;
          cam_wr    = 1'b1;
        end else begin
          man_wr = man_valid_in;
        end
      end
      ACQUIRE: begin
        // The confirming sample takes over staging even if a button pose collides.
        if (accept && confirm_done) begin
          to_camera = 1'b1;
          cam_wr    = 1'b1;
        end else begin
          man_wr    = man_valid_in;
          to_manual = !accept && timed_out;
        end
      end
      CAMERA: begin
        cam_wr    = accept;
        to_manual = !accept && timed_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state          <= MANUAL;
      timeout_cnt    <= '0;
      confirm_cnt    <= '0;
      staging        <= '0;
      released       <= '0;
      pending        <= 1'b0;
      pose_valid_out <= 1'b0;
      source_out     <= 1'b0;
    end else begin
      if (cam_wr) begin
        staging <= cam_pose;
      end else if (man_wr) begin
        staging <= man_pose;
      end

      // Release uses pre-write staging; a same-cycle write keeps pending set.
      if (release_now) begin
        released <= staging;
      end
      pose_valid_out <= release_now;
      pending        <= cam_wr || man_wr || (pending && !frame_start_in);

      unique case (state)
        MANUAL: begin
          timeout_cnt <= '0;
          if (accept) begin
            confirm_cnt <= CW'(1);
            if (to_camera) begin
              state      <= CAMERA;
              source_out <= 1'b1;
            end else begin
              state <= ACQUIRE;
            end
          end
        end
        ACQUIRE: begin
          if (accept) begin
            confirm_cnt <= confirm_cnt + 1'b1;
            timeout_cnt <= '0;
            if (to_camera) begin
              state      <= CAMERA;
              source_out <= 1'b1;
            end
          end else if (to_manual) begin
            state       <= MANUAL;
            confirm_cnt <= '0;
            timeout_cnt <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        CAMERA: begin
          if (accept) begin
            timeout_cnt <= '0;
          end else if (to_manual) begin
            state       <= MANUAL;
            source_out  <= 1'b0;
            confirm_cnt <= '0;
            timeout_cnt <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        default: state <= MANUAL;
      endcase
    end
  end

  assign hand_x_left_bottom = released[75:64];
  assign hand_y_left_bottom = released[63:52];
  assign hand_z_left_bottom = released[51:38];
  assign hand_x_left_top    = released[37:26];
  assign hand_y_left_top    = released[25:14];
  assign hand_z_left_top    = released[13:0];

endmodule
